branch_resolve_ctrl: RTL and testbench

Sequencing controller for the 2-bit branch predictor. It tracks conditional branches in flight from the predict stage to the resolve stage and drives the predictor's training inputs on resolution. On a mispredict it issues a flush and a redirect PC. It sits between fetch/decode, the EX stage and the predictor FSM, and is the only agent that trains the predictor.

---
 rtl/bp_pkg.sv | 13 +
 rtl/bp_inflight_fifo.sv | 52 +++++
 rtl/branch_resolve_ctrl.sv | 117 +++++++++++
 tb/tb_branch_resolve_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and constants for the branch resolve controller.
package bp_pkg;
  localparam int PC_W       = 32;
  localparam int MISP_CNT_W = 16;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  // In-flight entry layout. The FIFO stores it as a flat {taken, alt_pc} word.
  typedef struct packed {
    logic            taken;
    logic [PC_W-1:0] alt_pc;
  } entry_t;
endpackage

// File: rtl/bp_inflight_fifo.sv
// In-flight branch FIFO: push/pop/clear, power-of-two depth, separate count.
module bp_inflight_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [W-1:0]             i_wdata,
  output logic [W-1:0]             o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_rdata = r_mem[r_rp];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Pointers and count; clear wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Storage needs no reset; only entries below the count are ever read.
  always_ff @(posedge clk) begin
    if (w_push && !i_clear) r_mem[r_wp] <= i_wdata;
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks predicted branches until EX resolves them, trains the predictor,
// and on mispredict clears the queue, redirects fetch and holds flush.
module branch_resolve_ctrl
  import bp_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int PC_W         = bp_pkg::PC_W,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid_i,
  input  logic                  pred_taken_i,
  input  logic [PC_W-1:0]       alt_pc_i,
  output logic                  pred_ready_o,
  input  logic                  res_valid_i,
  input  logic                  res_taken_i,
  output logic                  upd_valid_o,
  output logic                  upd_taken_o,
  output logic                  flush_o,
  output logic                  redirect_valid_o,
  output logic [PC_W-1:0]       redirect_pc_o,
  output logic [MISP_CNT_W-1:0] mispredict_cnt_o,
  output logic                  err_o
);
  localparam int CW = $clog2(DEPTH);

  state_e                r_state, w_state_nxt;
  logic [2:0]            r_flush_cnt, w_flush_cnt_nxt;
  logic [PC_W:0]         w_head;
  logic [CW:0]           w_count;
  logic                  w_full, w_empty;
  logic                  w_run, w_push, w_pop, w_misp, w_err_set;
  logic                  r_upd_valid, r_upd_taken, r_redir_valid, r_flush, r_err;
  logic [PC_W-1:0]       r_redir_pc;
  logic [MISP_CNT_W-1:0] r_misp_cnt;

  // Head word is {taken, alt_pc}, matching entry_t.
  assign w_run     = (r_state == RUN);
  // Gated by reset so every output reads 0 while reset is held.
  assign pred_ready_o = rst & w_run & ~w_full;
  assign w_push    = pred_valid_i & pred_ready_o;
  assign w_pop     = res_valid_i & w_run & (w_count != '0);
  assign w_misp    = w_pop & (w_head[PC_W] != res_taken_i);
  assign w_err_set = res_valid_i & w_run & w_empty;

  // A mispredict clears the queue; the clear also discards a same-cycle push.
  bp_inflight_fifo #(.DEPTH(DEPTH), .W(PC_W+1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (w_misp),
    .i_wdata ({pred_taken_i, alt_pc_i}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State and flush counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Next state: FLUSH lasts FLUSH_CYCLES cycles, counting down to 0.
  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    case (r_state)
      RUN: if (w_misp) begin
        w_state_nxt     = FLUSH;
        w_flush_cnt_nxt = 3'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (r_flush_cnt == '0) w_state_nxt = RUN;
        else                   w_flush_cnt_nxt = r_flush_cnt - 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Registered outputs, one cycle after the resolving edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_upd_valid   <= 1'b0;
      r_upd_taken   <= 1'b0;
      r_redir_valid <= 1'b0;
      r_redir_pc    <= '0;
      r_flush       <= 1'b0;
      r_misp_cnt    <= '0;
      r_err         <= 1'b0;
    end else begin
      r_upd_valid   <= w_pop;
      r_upd_taken   <= w_pop & res_taken_i;
      r_redir_valid <= w_misp;
      r_flush       <= (w_state_nxt == FLUSH);
      if (w_misp) r_redir_pc <= w_head[PC_W-1:0];
      if (w_misp && r_misp_cnt != '1) r_misp_cnt <= r_misp_cnt + 1'b1;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign upd_valid_o      = r_upd_valid;
  assign upd_taken_o      = r_upd_taken;
  assign redirect_valid_o = r_redir_valid;
  assign redirect_pc_o    = r_redir_pc;
  assign flush_o          = r_flush;
  assign mispredict_cnt_o = r_misp_cnt;
  assign err_o            = r_err;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench: per-cycle queue model plus directed literal checks
// and a randomized phase.
module tb_branch_resolve_ctrl;
  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int FLUSH_CYCLES = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pred_valid_i = 0, pred_taken_i = 0, res_valid_i = 0, res_taken_i = 0;
  logic [PC_W-1:0] alt_pc_i = '0;
  logic            pred_ready_o, upd_valid_o, upd_taken_o, flush_o, redirect_valid_o, err_o;
  logic [PC_W-1:0] redirect_pc_o;
  logic [15:0]     mispredict_cnt_o;

  int checks = 0;
  int errors = 0;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .PC_W(PC_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .pred_valid_i(pred_valid_i), .pred_taken_i(pred_taken_i), .alt_pc_i(alt_pc_i),
    .pred_ready_o(pred_ready_o),
    .res_valid_i(res_valid_i), .res_taken_i(res_taken_i),
    .upd_valid_o(upd_valid_o), .upd_taken_o(upd_taken_o), .flush_o(flush_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .mispredict_cnt_o(mispredict_cnt_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: queue of {taken, alt_pc} and remaining flush cycles.
  logic [PC_W:0]   mq[$];
  int              m_flush_left;
  bit              m_upd_v, m_upd_t, m_redir_v, m_err;
  logic [PC_W-1:0] m_redir_pc;
  int              m_cnt;

  always @(posedge clk or negedge rst) begin : model
    bit rdy;
    logic [PC_W:0] h;
    if (!rst) begin
      mq.delete();
      m_flush_left = 0; m_upd_v = 0; m_upd_t = 0; m_redir_v = 0;
      m_redir_pc = '0; m_cnt = 0; m_err = 0;
    end else begin
      rdy = (m_flush_left == 0) && (mq.size() < DEPTH);
      m_upd_v = 0; m_upd_t = 0; m_redir_v = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else begin
        if (res_valid_i && mq.size() == 0) m_err = 1;
        if (res_valid_i && mq.size() > 0) begin
          h = mq.pop_front();
          m_upd_v = 1; m_upd_t = res_taken_i;
          if (h[PC_W] != res_taken_i) begin
            mq.delete();
            m_redir_v = 1; m_redir_pc = h[PC_W-1:0];
            if (m_cnt < 65535) m_cnt++;
            m_flush_left = FLUSH_CYCLES;
            rdy = 0;
          end
        end
        if (pred_valid_i && rdy) mq.push_back({pred_taken_i, alt_pc_i});
      end
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    chk("pred_ready", pred_ready_o, rst && m_flush_left == 0 && mq.size() < DEPTH);
    chk("upd_valid", upd_valid_o, m_upd_v);
    if (m_upd_v) chk("upd_taken", upd_taken_o, m_upd_t);
    chk("flush", flush_o, m_flush_left > 0);
    chk("redirect_valid", redirect_valid_o, m_redir_v);
    chk("redirect_pc", redirect_pc_o, m_redir_pc);
    chk("misp_cnt", mispredict_cnt_o, m_cnt);
    chk("err", err_o, m_err);
  end

  task automatic cyc(input bit pv, input bit pt, input logic [31:0] alt, input bit rv, input bit rt);
    pred_valid_i = pv; pred_taken_i = pt; alt_pc_i = alt;
    res_valid_i = rv; res_taken_i = rt;
    @(posedge clk); #1;
    pred_valid_i = 0; pred_taken_i = 0; alt_pc_i = '0;
    res_valid_i = 0; res_taken_i = 0;
  endtask

  initial begin
    #3;
    chk("rst_ready", pred_ready_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_cnt", mispredict_cnt_o, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("lit_ready_after_rst", pred_ready_o, 1);

    // Correct prediction
    cyc(1, 1, 32'h104, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("lit_upd_valid", upd_valid_o, 1);
    chk("lit_upd_taken", upd_taken_o, 1);
    chk("lit_no_flush", flush_o, 0);

    // Mispredict
    cyc(1, 1, 32'h200, 0, 0);
    cyc(0, 0, 0, 1, 0);
    chk("lit_redir_v", redirect_valid_o, 1);
    chk("lit_redir_pc", redirect_pc_o, 32'h200);
    chk("lit_flush1", flush_o, 1);
    chk("lit_ready_fl1", pred_ready_o, 0);
    chk("lit_cnt1", mispredict_cnt_o, 1);
    cyc(0, 0, 0, 0, 0);
    chk("lit_flush2", flush_o, 1);
    chk("lit_redir_pulse", redirect_valid_o, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_flush_end", flush_o, 0);
    chk("lit_ready_back", pred_ready_o, 1);

    // Full queue: push with same-cycle pop is refused
    for (int i = 0; i < 4; i++) cyc(1, 0, 32'h600 + 4*i, 0, 0);
    chk("lit_full_ready", pred_ready_o, 0);
    cyc(1, 0, 32'h999, 1, 0);
    chk("lit_cnt3_ready", pred_ready_o, 1);
    chk("lit_pop_upd", upd_valid_o, 1);
    cyc(1, 1, 32'h700, 0, 0);
    chk("lit_refull", pred_ready_o, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 0);
      chk("lit_b2b_upd", upd_valid_o, 1);
    end
    cyc(0, 0, 0, 1, 1);
    chk("lit_last_upd", upd_valid_o, 1);
    chk("lit_no_flush_drain", flush_o, 0);
    chk("lit_err_clear", err_o, 0);

    // Mispredict with 3 queued and a simultaneous push
    for (int i = 0; i < 3; i++) cyc(1, 1, 32'h300 + 4*i, 0, 0);
    cyc(1, 0, 32'h400, 1, 0);
    chk("lit_redir_pc3", redirect_pc_o, 32'h300);
    chk("lit_cnt2", mispredict_cnt_o, 2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("lit_empty_no_upd", upd_valid_o, 0);
    chk("lit_err_set", err_o, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("lit_err_sticky", err_o, 1);

    // Reset in the second flush cycle
    cyc(1, 1, 32'h500, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit_fl2_before_rst", flush_o, 1);
    #2 rst = 0;
    #1;
    chk("lit_arst_flush", flush_o, 0);
    chk("lit_arst_ready", pred_ready_o, 0);
    chk("lit_arst_cnt", mispredict_cnt_o, 0);
    chk("lit_arst_err", err_o, 0);
    chk("lit_arst_pc", redirect_pc_o, 0);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    chk("lit_post_ready", pred_ready_o, 1);
    chk("lit_post_cnt", mispredict_cnt_o, 0);

    // Randomized phase
    for (int n = 0; n < 4000; n++) begin
      bit pv, pt, rv, rt;
      pv = ($urandom_range(0, 99) < 60);
      pt = 1'($urandom);
      rv = ($urandom_range(0, 99) < 50);
      rt = 1'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 9) < 8) rt = mq[0][PC_W];
      if ($urandom_range(0, 999) == 0) begin
        rst = 0; #6; rst = 1;
      end
      cyc(pv, pt, $urandom, rv, rt);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
